// File: rtl/irq_ctrl_pkg.sv
// Shared types and register map for the interrupt controller.
// Pure declarations; no latency or flow control.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_EDGE    = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source synchronizer with rising-edge detect: lvl_o lags src_i by SYNC_STAGES edges.
// rise_o is a one-cycle pulse in the first cycle the synced level is high; no backpressure.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src_i,
  output logic lvl_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      lvl_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], src_i};
      lvl_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign lvl_o  = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~lvl_prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller: pending -> irq_o one edge later; ack drops irq_o on the sampling edge.
// Core paces it via ack/eoi; a request is held until ack or withdrawal, no nesting.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int ID_W        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src_i,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [N_SRC-1:0] cfg_wdata,
  output logic [N_SRC-1:0] cfg_rdata,
  output logic             irq_o,
  output logic [ID_W-1:0]  irq_id_o,
  input  logic             irq_ack_i,
  input  logic             irq_eoi_i
);

  logic [N_SRC-1:0] lvl, rise;
  logic [N_SRC-1:0] enable_q, edge_q, pending_q, pending_d;
  logic [N_SRC-1:0] cand, id_onehot, w1c, edge_chg, ack_clr;
  logic [ID_W-1:0]  win_id;
  logic             cand_any, cand_cur, ack_take;
  irq_state_t       state_q;
  logic [N_SRC+ID_W:0] status_full;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .src_i  (src_i[g]),
      .lvl_o  (lvl[g]),
      .rise_o (rise[g])
    );
  end

  assign cand      = pending_q & enable_q;
  assign cand_any  = |cand;
  assign id_onehot = N_SRC'(1) << irq_id_o;
  assign cand_cur  = |(cand & id_onehot);
  assign ack_take  = (state_q == REQ) && irq_ack_i;

  assign w1c      = (cfg_we && cfg_addr == ADDR_PENDING) ? cfg_wdata : '0;
  assign edge_chg = (cfg_we && cfg_addr == ADDR_EDGE) ? (cfg_wdata ^ edge_q) : '0;
  assign ack_clr  = ack_take ? id_onehot : '0;

  // Lowest index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) win_id = ID_W'(i);
    end
  end

  // A fresh edge outranks W1C and the ack clear; a mode change clears the bit outright.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (edge_chg[i])
        pending_d[i] = 1'b0;
      else if (edge_q[i])
        pending_d[i] = rise[i] | (pending_q[i] & ~w1c[i] & ~ack_clr[i]);
      else
        pending_d[i] = lvl[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q  <= '0;
      edge_q    <= '0;
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
      if (cfg_we && cfg_addr == ADDR_ENABLE) enable_q <= cfg_wdata;
      if (cfg_we && cfg_addr == ADDR_EDGE)   edge_q   <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      irq_o    <= 1'b0;
      irq_id_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cand_any) begin
            state_q  <= REQ;
            irq_o    <= 1'b1;
            irq_id_o <= win_id;
          end
        end
        REQ: begin
          if (irq_ack_i) begin
            state_q <= SERVICE;
            irq_o   <= 1'b0;
          end else if (!cand_cur) begin
            state_q <= IDLE;
            irq_o   <= 1'b0;
          end
        end
        SERVICE: begin
          if (irq_eoi_i) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          irq_o   <= 1'b0;
        end
      endcase
    end
  end

  assign status_full = {{N_SRC{1'b0}}, irq_id_o, (state_q != IDLE)};

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_ENABLE:  cfg_rdata = enable_q;
      ADDR_EDGE:    cfg_rdata = edge_q;
      ADDR_PENDING: cfg_rdata = pending_q;
      ADDR_STATUS:  cfg_rdata = status_full[N_SRC-1:0];
      default:      cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: register vector table, then handshake sequences with an ID scoreboard.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] src_i;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [3:0] cfg_wdata;
  logic [3:0] cfg_rdata;
  logic       irq_o;
  logic [1:0] irq_id_o;
  logic       irq_ack_i;
  logic       irq_eoi_i;

  irq_ctrl #(.N_SRC(4), .ID_W(2), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_i     (src_i),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .irq_o     (irq_o),
    .irq_id_o  (irq_id_o),
    .irq_ack_i (irq_ack_i),
    .irq_eoi_i (irq_eoi_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [3:0] wdata;
    logic [3:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[10];
  int       n_chk = 0;
  int       n_fail = 0;
  int       exp_q[$];
  logic     irq_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every clock step also scores each new irq_o assertion against the expected-ID queue.
  task automatic tick();
    @(posedge clk);
    #1;
    if (irq_o === 1'b1 && irq_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_irq: got id %0d expected no request", irq_id_o);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("sb_irq_id", {30'd0, irq_id_o}, e);
      end
    end
    irq_prev = irq_o;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [3:0] data);
    cfg_we = 1'b1;
    cfg_addr = addr;
    cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] addr, input logic [3:0] exp);
    cfg_addr = addr;
    #1;
    chk(name, {28'd0, cfg_rdata}, {28'd0, exp});
  endtask

  task automatic pulse_ack();
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
  endtask

  task automatic pulse_eoi();
    irq_eoi_i = 1'b1;
    tick();
    irq_eoi_i = 1'b0;
  endtask

  task automatic wait_irq(input logic val, input int budget, input string name);
    int k = 0;
    while (irq_o !== val && k < budget) begin
      tick();
      k++;
    end
    chk(name, {31'd0, irq_o}, {31'd0, val});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, ADDR_ENABLE,  4'h0, 4'h0};
    vecs[1] = '{1'b0, ADDR_EDGE,    4'h0, 4'h0};
    vecs[2] = '{1'b0, ADDR_PENDING, 4'h0, 4'h0};
    vecs[3] = '{1'b0, ADDR_STATUS,  4'h0, 4'h0};
    vecs[4] = '{1'b1, ADDR_ENABLE,  4'ha, 4'ha};
    vecs[5] = '{1'b1, ADDR_EDGE,    4'h6, 4'h6};
    vecs[6] = '{1'b1, ADDR_STATUS,  4'hf, 4'h0};
    vecs[7] = '{1'b1, ADDR_PENDING, 4'hf, 4'h0};
    vecs[8] = '{1'b1, ADDR_ENABLE,  4'h0, 4'h0};
    vecs[9] = '{1'b1, ADDR_EDGE,    4'h0, 4'h0};

    rst_n = 1'b0;
    src_i = '0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    irq_ack_i = 1'b0;
    irq_eoi_i = 1'b0;
    #12;
    chk("rst_irq_o", {31'd0, irq_o}, 0);
    chk("rst_irq_id", {30'd0, irq_id_o}, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
      rd_chk($sformatf("regvec%0d", i), vecs[i].addr, vecs[i].exp);
      chk($sformatf("regvec%0d_irq", i), {31'd0, irq_o}, 0);
    end

    // Edge source 0: one-cycle pulse, exact latency.
    wr(ADDR_ENABLE, 4'b0001);
    wr(ADDR_EDGE, 4'b0001);
    src_i[0] = 1'b1;
    exp_q.push_back(0);
    tick();
    src_i[0] = 1'b0;
    tick();
    tick();
    chk("lat_e2_irq_low", {31'd0, irq_o}, 0);
    rd_chk("lat_e2_pending", ADDR_PENDING, 4'b0001);
    tick();
    chk("lat_e3_irq_high", {31'd0, irq_o}, 1);
    rd_chk("req_status", ADDR_STATUS, 4'b0001);
    pulse_ack();
    chk("ack_irq_low", {31'd0, irq_o}, 0);
    rd_chk("ack_pending_clr", ADDR_PENDING, 4'b0000);
    pulse_eoi();
    rd_chk("eoi_not_busy", ADDR_STATUS, 4'b0000);

    // Two simultaneous edges: priority, then one idle cycle before the second request.
    wr(ADDR_ENABLE, 4'b1111);
    wr(ADDR_EDGE, 4'b1111);
    src_i[3] = 1'b1;
    src_i[1] = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(3);
    wait_irq(1'b1, 10, "prio_req");
    pulse_ack();
    pulse_eoi();
    chk("gap_after_eoi", {31'd0, irq_o}, 0);
    tick();
    chk("second_req", {31'd0, irq_o}, 1);
    rd_chk("second_status", ADDR_STATUS, 4'b0111);
    pulse_ack();
    pulse_eoi();
    src_i = '0;

    // Level source 2: re-request after EOI, withdrawal without ack.
    wr(ADDR_EDGE, 4'b1011);
    wr(ADDR_ENABLE, 4'b0100);
    src_i[2] = 1'b1;
    exp_q.push_back(2);
    wait_irq(1'b1, 10, "lvl_req");
    pulse_ack();
    rd_chk("lvl_pending_held", ADDR_PENDING, 4'b0100);
    exp_q.push_back(2);
    pulse_eoi();
    rd_chk("lvl_idle_at_eoi", ADDR_STATUS, 4'b0100);
    tick();
    chk("lvl_rereq", {31'd0, irq_o}, 1);
    src_i[2] = 1'b0;
    wait_irq(1'b0, 10, "lvl_withdraw");
    rd_chk("lvl_withdraw_idle", ADDR_STATUS, 4'b0100);

    // Pending but disabled, then enable; W1C colliding with a new edge.
    wr(ADDR_EDGE, 4'b1111);
    wr(ADDR_ENABLE, 4'b0000);
    src_i[0] = 1'b1;
    tick();
    src_i[0] = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("disabled_no_irq", {31'd0, irq_o}, 0);
    rd_chk("disabled_pending", ADDR_PENDING, 4'b0001);
    exp_q.push_back(0);
    wr(ADDR_ENABLE, 4'b0001);
    chk("enable_edge_irq_low", {31'd0, irq_o}, 0);
    tick();
    chk("enable_next_irq", {31'd0, irq_o}, 1);
    pulse_ack();
    pulse_eoi();
    src_i[0] = 1'b1;
    tick();
    src_i[0] = 1'b0;
    tick();
    exp_q.push_back(0);
    wr(ADDR_PENDING, 4'b0001);
    rd_chk("set_beats_w1c", ADDR_PENDING, 4'b0001);
    wait_irq(1'b1, 5, "w1c_collision_req");
    pulse_ack();
    pulse_eoi();

    // No re-arbitration in REQ; ignored handshakes.
    wr(ADDR_ENABLE, 4'b1111);
    src_i[1] = 1'b1;
    exp_q.push_back(1);
    wait_irq(1'b1, 10, "norearb_req");
    src_i[0] = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("norearb_id", {30'd0, irq_id_o}, 1);
    chk("norearb_irq", {31'd0, irq_o}, 1);
    pulse_eoi();
    chk("eoi_in_req_irq", {31'd0, irq_o}, 1);
    rd_chk("eoi_in_req_status", ADDR_STATUS, 4'b0011);
    pulse_ack();
    pulse_ack();
    rd_chk("ack_in_service", ADDR_STATUS, 4'b0011);
    exp_q.push_back(0);
    pulse_eoi();
    chk("gap2_after_eoi", {31'd0, irq_o}, 0);
    tick();
    chk("src0_req", {31'd0, irq_o}, 1);
    irq_ack_i = 1'b1;
    irq_eoi_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    irq_eoi_i = 1'b0;
    rd_chk("ack_eoi_together", ADDR_STATUS, 4'b0001);
    pulse_eoi();
    src_i = '0;

    // Asynchronous reset in SERVICE.
    src_i[2] = 1'b1;
    exp_q.push_back(2);
    wait_irq(1'b1, 10, "pre_rst_req");
    pulse_ack();
    rst_n = 1'b0;
    #1;
    chk("arst_irq_o", {31'd0, irq_o}, 0);
    chk("arst_irq_id", {30'd0, irq_id_o}, 0);
    rd_chk("arst_enable", ADDR_ENABLE, 4'h0);
    rd_chk("arst_edge", ADDR_EDGE, 4'h0);
    rd_chk("arst_pending", ADDR_PENDING, 4'h0);
    rd_chk("arst_status", ADDR_STATUS, 4'h0);
    src_i = '0;
    #1;
    rst_n = 1'b1;
    tick();
    wr(ADDR_ENABLE, 4'b0100);
    wr(ADDR_EDGE, 4'b0100);
    for (int i = 0; i < 4; i++) tick();
    chk("no_req_after_rst", {31'd0, irq_o}, 0);
    src_i[2] = 1'b1;
    exp_q.push_back(2);
    wait_irq(1'b1, 10, "req_after_rst");
    pulse_ack();
    pulse_eoi();
    src_i = '0;
    tick();

    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller in front of the pipelined CPU core.
- Collects up to N external interrupt sources and applies per-source enable and edge/level configuration.
- Picks the highest-priority pending source and presents a single request plus source ID to the core, with an ack/end-of-interrupt handshake.
- Its `irq_o` drives the core's `irq[0]` line.
- Configured by the core through a small 4-word register port.

Parameters:
- `N_SRC`, 4: number of interrupt sources (1..32).
- `ID_W`, 2: width of the source ID, equal to clog2(`N_SRC`), minimum 1.
- `SYNC_STAGES`, 2: synchronizer flops per source (2..3).

Ports:
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `src_i` in `N_SRC`: raw asynchronous interrupt sources, active high.
- `cfg_we` in 1: register write strobe, one cycle.
- `cfg_addr` in 2: register address.
- `cfg_wdata` in `N_SRC`: register write data.
- `cfg_rdata` out `N_SRC`: register read data, combinational from `cfg_addr`.
- `irq_o` out 1: interrupt request to the core.
- `irq_id_o` out `ID_W`: ID of the requested or in-service source.
- `irq_ack_i` in 1: core has taken the request (trap entry), one-cycle pulse.
- `irq_eoi_i` in 1: core has finished the handler (mret), one-cycle pulse.

Behaviour:
- Clock and reset:
  - One clock (`clk`); reset is asynchronous and active-low (`rst_n`).
  - On reset, all registers clear: ENABLE=0, EDGE=0, PENDING=0, state=IDLE, `irq_o`=0, `irq_id_o`=0, synchronizers=0.
- Register map:
  - 0 ENABLE (rw).
  - 1 EDGE (rw): 1 = rising-edge source, 0 = level-high source.
  - 2 PENDING (r; write-1-to-clear, edge bits only).
  - 3 STATUS (r): bit0 = busy (state != IDLE), bits [`ID_W`:1] = current ID; writes ignored. If `N_SRC` < `ID_W`+1, STATUS truncates to `N_SRC` bits.
- Source conditioning:
  - Each `src_i` bit passes through `SYNC_STAGES` flops.
  - Edge sources: PENDING bit sets on synced 0->1.
  - Level sources: PENDING bit equals the synced level every cycle; W1C has no effect.
- Pending collisions:
  - Set and W1C on the same edge bit in the same cycle: set wins.
  - Writing EDGE changes a bit's mode next cycle and clears that PENDING bit.
- Candidate selection:
  - Candidate = PENDING & ENABLE.
  - Fixed priority: lowest index wins.
- FSM IDLE / REQ / SERVICE:
  - IDLE -> REQ when any candidate bit is set. Latch `irq_id_o` = winner; `irq_o`=1 from the next cycle.
  - REQ:
    - `irq_o` held high and `irq_id_o` stable; no re-arbitration, even if a higher-priority source arrives.
    - On `irq_ack_i`: go to SERVICE, `irq_o`=0 next cycle, and clear the PENDING bit of `irq_id_o` if it is an edge source.
    - If the latched source leaves the candidate set (disabled, cleared, or level dropped) without ack: return to IDLE, `irq_o`=0 next cycle.
    - Ack in the same cycle as withdrawal: ack wins.
  - SERVICE:
    - `irq_o`=0, `irq_id_o` held.
    - On `irq_eoi_i`: go to IDLE. Arbitration resumes the following cycle, so there is at least one idle cycle between EOI and the next `irq_o`.
    - No nesting.
  - Ignored handshakes: `irq_ack_i` in IDLE or SERVICE; `irq_eoi_i` in IDLE or REQ.
  - Ack and EOI asserted together in REQ: ack taken, EOI ignored.
- Latency, `SYNC_STAGES`=2, edge source, `src_i` rising before clk edge E0:
  - PENDING set at E2.
  - State REQ and `irq_o`=1 at E3.
  - Ack sampled at edge Ea -> `irq_o`=0 at Ea.
- Level source: if still high after EOI, it re-requests (IDLE at Ee, REQ at Ee+1).
- Reset mid-handshake: immediate return to the reset values above, asynchronously.

Decomposition:
- Package `irq_ctrl_pkg` holds:
  - state enum: IDLE=2'd0, REQ=2'd1, SERVICE=2'd2;
  - register address constants: ADDR_ENABLE=0, ADDR_EDGE=1, ADDR_PENDING=2, ADDR_STATUS=3.
- Sub-module `irq_sync_edge`: one per source (generate loop). It contains the `SYNC_STAGES` synchronizer and outputs `lvl_o` and `rise_o`.
- Priority encoder, PENDING/ENABLE/EDGE registers and the FSM live in `irq_ctrl`.

Test Plan:
- Reset, then ENABLE=4'b0001, EDGE=4'b0001, pulse `src_i[0]` high for 1 cycle -> `irq_o`=1 three edges later with `irq_id_o`=0; ack -> `irq_o`=0 and PENDING=0; EOI -> STATUS.busy=0.
- ENABLE=4'b1111, EDGE=4'b1111, raise `src_i[3]` and `src_i[1]` in the same cycle -> `irq_id_o`=1. After ack+EOI -> second request with `irq_id_o`=3, and one idle cycle between them.
- Level source 2 (EDGE[2]=0, ENABLE[2]=1): hold `src_i[2]` high through ack and EOI -> re-request with `irq_id_o`=2. Drop `src_i[2]` while in REQ -> `irq_o` falls without ack, state returns to IDLE.
- Edge source 0 pending but ENABLE=0 -> no `irq_o`. Write ENABLE=1 -> `irq_o` next cycle. In the same cycle as a new edge on src 0, write 1 to PENDING[0] -> PENDING[0] stays 1.
- In REQ with `irq_id_o`=1, raise higher-priority `src_i[0]` -> `irq_id_o` stays 1 until ack. Spurious EOI in REQ and ack in SERVICE -> no state change.
- Assert `rst_n`=0 mid-SERVICE -> `irq_o`=0, all registers 0 immediately. After release, no request until a new edge arrives.
